// File: rtl/wb_arbiter_pkg.sv
// Shared types for the decode-stage register-file write-back path.
// Holds register naming and the write-back source tag.
package wb_arbiter_pkg;

  localparam int REG_COUNT = 32;

  typedef logic [$clog2(REG_COUNT)-1:0] regName_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2
  } wb_src_t;

  // x0 is hard-wired to zero, so only non-zero destinations need the port.
  function automatic logic needs_port(input logic valid, input regName_t rd);
    return valid && (rd != regName_t'(0));
  endfunction

endpackage

// File: rtl/wb_arbiter.sv
// Merges the ALU and load write-back requesters onto the single registered
// register-file write port, with fixed ALU priority and load anti-starvation.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  regName_t              alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  regName_t              mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  output logic                  rf_wen,
  output regName_t              rf_rd,
  output logic [DATA_WIDTH-1:0] rf_data,
  output wb_src_t               rf_src
);

  localparam logic [2:0] MAX_WAIT_C = 3'(MAX_WAIT);

  logic                  alu_nz_s;
  logic                  mem_nz_s;
  logic                  alu_grant_s;
  logic                  mem_grant_s;
  logic [2:0]            starve_d;
  logic [2:0]            starve_q;
  logic                  wen_d;
  logic                  wen_q;
  regName_t              rd_d;
  regName_t              rd_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] data_q;
  wb_src_t               src_d;
  wb_src_t               src_q;

  // Grant decision: the load wins when alone or once it has waited MAX_WAIT cycles.
  always_comb begin
    alu_nz_s    = needs_port(alu_valid, alu_rd);
    mem_nz_s    = needs_port(mem_valid, mem_rd);
    mem_grant_s = mem_nz_s && (!alu_nz_s || (starve_q == MAX_WAIT_C));
    alu_grant_s = alu_nz_s && !mem_grant_s;
    if (rst) begin
      alu_ready = 1'b0;
      mem_ready = 1'b0;
    end else begin
      // x0 requests are accepted without ever consuming the port.
      alu_ready = alu_valid && ((alu_rd == regName_t'(0)) || alu_grant_s);
      mem_ready = mem_valid && ((mem_rd == regName_t'(0)) || mem_grant_s);
    end
  end

  // Next-state for the starve counter and the registered write port.
  always_comb begin
    starve_d = 3'd0;
    wen_d    = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    src_d    = WB_NONE;
    if (mem_nz_s && !mem_grant_s) begin
      starve_d = (starve_q >= MAX_WAIT_C) ? MAX_WAIT_C : starve_q + 3'd1;
    end else begin
      starve_d = 3'd0;
    end
    case ({alu_grant_s, mem_grant_s})
      2'b10: begin
        wen_d  = 1'b1;
        rd_d   = alu_rd;
        data_d = alu_data;
        src_d  = WB_ALU;
      end
      2'b01: begin
        wen_d  = 1'b1;
        rd_d   = mem_rd;
        data_d = mem_data;
        src_d  = WB_MEM;
      end
      default: begin
        wen_d  = 1'b0;
        src_d  = WB_NONE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 3'd0;
      wen_q    <= 1'b0;
      rd_q     <= regName_t'(0);
      data_q   <= {DATA_WIDTH{1'b0}};
      src_q    <= WB_NONE;
    end else begin
      starve_q <= starve_d;
      wen_q    <= wen_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      src_q    <= src_d;
    end
  end

  assign rf_wen  = wen_q;
  assign rf_rd   = rd_q;
  assign rf_data = data_q;
  assign rf_src  = src_q;

endmodule
